rv32_multicycle_ctrl: RTL and testbench



---
 rtl/rv32_multicycle_ctrl_pkg.sv | 73 +++++++
 rtl/rv32_multicycle_ctrl_if.sv | 35 +++
 rtl/rv32_branch_cond.sv | 25 ++
 rtl/rv32_multicycle_ctrl.sv | 138 +++++++++++++
 tb/tb_rv32_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller and its datapath neighbours.
package rv32_ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [2:0] ImmNone  = 3'b000;
  localparam logic [2:0] ImmI     = 3'b001;
  localparam logic [2:0] ImmS     = 3'b010;
  localparam logic [2:0] ImmB     = 3'b011;
  localparam logic [2:0] ImmU     = 3'b100;
  localparam logic [2:0] ImmJ     = 3'b101;
  localparam logic [2:0] ImmShamt = 3'b110;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b1000;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJalr   = 2'b10;

  localparam logic [1:0] WbAluOut = 2'b00;
  localparam logic [1:0] WbMem    = 2'b01;
  localparam logic [1:0] WbPc     = 2'b10;

  localparam logic [1:0] SrcARs1   = 2'b00;
  localparam logic [1:0] SrcAPc    = 2'b01;
  localparam logic [1:0] SrcAOldPc = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_src;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [2:0] imm_typ;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       halted;
  } ctrl_out_t;

  // Branch funct3 legality is handled by rv32_branch_cond.
  function automatic logic opcode_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OpR, OpImm, OpBranch, OpJal, OpLui, OpAuipc: return 1'b1;
      OpLoad:  return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OpStore: return f3 <= 3'b010;
      OpJalr:  return f3 == 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and datapath/memory.
interface rv32_multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_src;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic [2:0] imm_typ;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       reg_we;
  logic [1:0] wb_sel;
  logic       halted;

  modport master (
    input  opcode, funct3, funct7_5, zero, lt, ltu, mem_ready,
    output mem_req, mem_we, mem_src, ir_we, pc_we, pc_sel, imm_typ,
           alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, halted
  );

  modport slave (
    output opcode, funct3, funct7_5, zero, lt, ltu, mem_ready,
    input  mem_req, mem_we, mem_src, ir_we, pc_we, pc_sel, imm_typ,
           alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, halted
  );
endinterface

// File: rtl/rv32_branch_cond.sv
// Branch outcome from funct3 and the ALU compare flags of rs1 - rs2.
module rv32_branch_cond (
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      3'b000:  taken_o = zero_i;
      3'b001:  taken_o = ~zero_i;
      3'b100:  taken_o = lt_i;
      3'b101:  taken_o = ~lt_i;
      3'b110:  taken_o = ltu_i;
      3'b111:  taken_o = ~ltu_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb over one ALU and one memory port.
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  rv32_multicycle_ctrl_if.master ctrl_io
);

  state_e     state_q, state_d;
  ctrl_out_t  out;
  logic       br_taken, br_illegal, illegal;
  logic [6:0] op;
  logic [2:0] f3;

  assign op = ctrl_io.opcode;
  assign f3 = ctrl_io.funct3;

  rv32_branch_cond u_branch_cond (
    .funct3_i  (f3),
    .zero_i    (ctrl_io.zero),
    .lt_i      (ctrl_io.lt),
    .ltu_i     (ctrl_io.ltu),
    .taken_o   (br_taken),
    .illegal_o (br_illegal)
  );

  assign illegal = ~opcode_legal(op, f3) | ((op == OpBranch) & br_illegal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    out     = '0;
    unique case (state_q)
      StFetch: begin
        out.mem_req   = 1'b1;
        out.alu_src_a = SrcAPc;
        out.alu_src_b = SrcBFour;
        out.alu_op    = AluAdd;
        if (ctrl_io.mem_ready) begin
          out.ir_we  = 1'b1;
          out.pc_we  = 1'b1;
          out.pc_sel = PcAlu;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        // ALUOut captures old PC + imm here: the branch/JAL target used in EXEC.
        out.alu_src_a = SrcAOldPc;
        out.alu_src_b = SrcBImm;
        out.alu_op    = AluAdd;
        out.imm_typ   = (op == OpBranch) ? ImmB : (op == OpJal) ? ImmJ : ImmNone;
        if (illegal) state_d = HALT_ON_ILLEGAL ? StHalt : StFetch;
        else         state_d = StExec;
      end
      StExec: begin
        state_d = StWb;
        case (op)
          OpR: out.alu_op = {ctrl_io.funct7_5, f3};
          OpImm: begin
            out.alu_src_b = SrcBImm;
            out.imm_typ   = (f3 == 3'b001 || f3 == 3'b101) ? ImmShamt : ImmI;
            out.alu_op    = {ctrl_io.funct7_5 & (f3 == 3'b101), f3};
          end
          OpLoad, OpStore: begin
            out.alu_src_b = SrcBImm;
            out.imm_typ   = (op == OpLoad) ? ImmI : ImmS;
            state_d       = StMem;
          end
          OpBranch: begin
            out.alu_op = AluSub;
            out.pc_we  = br_taken;
            out.pc_sel = PcAluOut;
            state_d    = StFetch;
          end
          OpJal: begin
            out.pc_we  = 1'b1;
            out.pc_sel = PcAluOut;
          end
          OpJalr: begin
            out.alu_src_b = SrcBImm;
            out.imm_typ   = ImmI;
            out.pc_we     = 1'b1;
            out.pc_sel    = PcJalr;
          end
          OpLui: begin
            out.alu_src_a = SrcAZero;
            out.alu_src_b = SrcBImm;
            out.imm_typ   = ImmU;
          end
          OpAuipc: begin
            out.alu_src_a = SrcAOldPc;
            out.alu_src_b = SrcBImm;
            out.imm_typ   = ImmU;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        out.mem_req = 1'b1;
        out.mem_src = 1'b1;
        out.mem_we  = (op == OpStore);
        if (ctrl_io.mem_ready) state_d = (op == OpStore) ? StFetch : StWb;
      end
      StWb: begin
        out.reg_we = 1'b1;
        out.wb_sel = (op == OpLoad) ? WbMem :
                     (op == OpJal || op == OpJalr) ? WbPc : WbAluOut;
        state_d    = StFetch;
      end
      StHalt:  out.halted = 1'b1;
      default: state_d = StFetch;
    endcase
    // Reset masks outputs combinationally so an aborted access drops at once.
    if (rst) out = '0;
  end

  assign ctrl_io.mem_req   = out.mem_req;
  assign ctrl_io.mem_we    = out.mem_we;
  assign ctrl_io.mem_src   = out.mem_src;
  assign ctrl_io.ir_we     = out.ir_we;
  assign ctrl_io.pc_we     = out.pc_we;
  assign ctrl_io.pc_sel    = out.pc_sel;
  assign ctrl_io.imm_typ   = out.imm_typ;
  assign ctrl_io.alu_src_a = out.alu_src_a;
  assign ctrl_io.alu_src_b = out.alu_src_b;
  assign ctrl_io.alu_op    = out.alu_op;
  assign ctrl_io.reg_we    = out.reg_we;
  assign ctrl_io.wb_sel    = out.wb_sel;
  assign ctrl_io.halted    = out.halted;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Bench for rv32_multicycle_ctrl: vector table, hand sequences and a random instruction stream.
module tb_rv32_multicycle_ctrl;

  localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef logic [21:0] outv_t;
  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75;
    logic       z;
    logic       use_n;
    int         cyc;
    outv_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic f75, zf, ltf, ltuf, rdy;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  outv_t obs_h, obs_n, fetch_r, halt_v;

  always #5 clk = ~clk;

  rv32_multicycle_ctrl_if bh ();
  rv32_multicycle_ctrl_if bn ();

  rv32_multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut_h (.clk(clk), .rst(rst), .ctrl_io(bh.master));
  rv32_multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut_n (.clk(clk), .rst(rst), .ctrl_io(bn.master));

  assign bh.opcode = op;   assign bn.opcode = op;
  assign bh.funct3 = f3;   assign bn.funct3 = f3;
  assign bh.funct7_5 = f75; assign bn.funct7_5 = f75;
  assign bh.zero = zf;     assign bn.zero = zf;
  assign bh.lt = ltf;      assign bn.lt = ltf;
  assign bh.ltu = ltuf;    assign bn.ltu = ltuf;
  assign bh.mem_ready = rdy; assign bn.mem_ready = rdy;

  assign obs_h = {bh.mem_req, bh.mem_we, bh.mem_src, bh.ir_we, bh.pc_we, bh.pc_sel, bh.imm_typ,
                  bh.alu_src_a, bh.alu_src_b, bh.alu_op, bh.reg_we, bh.wb_sel, bh.halted};
  assign obs_n = {bn.mem_req, bn.mem_we, bn.mem_src, bn.ir_we, bn.pc_we, bn.pc_sel, bn.imm_typ,
                  bn.alu_src_a, bn.alu_src_b, bn.alu_op, bn.reg_we, bn.wb_sel, bn.halted};

  // Field order: req we src ir_we pc_we pc_sel imm a b alu_op reg_we wb_sel halted
  function automatic outv_t mkv(input int req, we, src, irwe, pcwe, pcsel, imm, a, b, alu,
                                input int regwe, wb, hlt);
    return {1'(req), 1'(we), 1'(src), 1'(irwe), 1'(pcwe), 2'(pcsel), 3'(imm), 2'(a), 2'(b),
            4'(alu), 1'(regwe), 2'(wb), 1'(hlt)};
  endfunction

  function automatic bit ref_legal(input logic [6:0] o, input logic [2:0] f);
    if (o inside {OP_R, OP_IMM, OP_JAL, OP_LUI, OP_AUIPC}) return 1'b1;
    if (o == OP_BR) return !(f inside {3'd2, 3'd3});
    if (o == OP_LD) return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (o == OP_ST) return f <= 3'd2;
    if (o == OP_JALR) return f == 3'd0;
    return 1'b0;
  endfunction

  function automatic bit ref_taken(input logic [2:0] f, input bit z, l, lu);
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return lu;
      3'd7: return !lu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic addv(input string nm, input logic [6:0] o, input logic [2:0] f, input bit s,
                      input bit z, input bit dn, input int c, input outv_t e);
    vec_t v;
    v.name = nm; v.op = o; v.f3 = f; v.f75 = s; v.z = z; v.use_n = dn; v.cyc = c; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f, input logic s,
                      input logic z, input logic l, input logic lu);
    @(posedge clk);
    #1;
    rdy = r; op = o; f3 = f; f75 = s; zf = z; ltf = l; ltuf = lu;
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] ops [9];
    ops = '{OP_R, OP_IMM, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    fetch_r = mkv(1, 0, 0, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    halt_v  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    addv("addi_fetch",  OP_IMM, 3'd0, 0, 0, 0, 0, fetch_r);
    addv("addi_decode", OP_IMM, 3'd0, 0, 0, 0, 1, mkv(0,0,0,0,0,0,0,2,1,0,0,0,0));
    addv("addi_exec",   OP_IMM, 3'd0, 1, 0, 0, 2, mkv(0,0,0,0,0,0,1,0,1,0,0,0,0));
    addv("addi_wb",     OP_IMM, 3'd0, 0, 0, 0, 3, mkv(0,0,0,0,0,0,0,0,0,0,1,0,0));
    addv("addi_next",   OP_IMM, 3'd0, 0, 0, 0, 4, fetch_r);
    addv("srai_exec",   OP_IMM, 3'd5, 1, 0, 0, 2, mkv(0,0,0,0,0,0,6,0,1,13,0,0,0));
    addv("srli_exec",   OP_IMM, 3'd5, 0, 0, 0, 2, mkv(0,0,0,0,0,0,6,0,1,5,0,0,0));
    addv("slli_exec",   OP_IMM, 3'd1, 1, 0, 0, 2, mkv(0,0,0,0,0,0,6,0,1,1,0,0,0));
    addv("sub_exec",    OP_R,   3'd0, 1, 0, 0, 2, mkv(0,0,0,0,0,0,0,0,0,8,0,0,0));
    addv("sra_exec",    OP_R,   3'd5, 1, 0, 0, 2, mkv(0,0,0,0,0,0,0,0,0,13,0,0,0));
    addv("beq_decode",  OP_BR,  3'd0, 0, 1, 0, 1, mkv(0,0,0,0,0,0,3,2,1,0,0,0,0));
    addv("beq_taken",   OP_BR,  3'd0, 0, 1, 0, 2, mkv(0,0,0,0,1,1,0,0,0,8,0,0,0));
    addv("beq_nottkn",  OP_BR,  3'd0, 0, 0, 0, 2, mkv(0,0,0,0,0,1,0,0,0,8,0,0,0));
    addv("bne_taken",   OP_BR,  3'd1, 0, 0, 0, 2, mkv(0,0,0,0,1,1,0,0,0,8,0,0,0));
    addv("beq_next",    OP_BR,  3'd0, 0, 1, 0, 3, fetch_r);
    addv("jal_decode",  OP_JAL, 3'd3, 0, 0, 0, 1, mkv(0,0,0,0,0,0,5,2,1,0,0,0,0));
    addv("jal_wb",      OP_JAL, 3'd3, 0, 0, 0, 3, mkv(0,0,0,0,0,0,0,0,0,0,1,2,0));
    addv("jalr_exec",   OP_JALR, 3'd0, 0, 0, 0, 2, mkv(0,0,0,0,1,2,1,0,1,0,0,0,0));
    addv("jalr_wb",     OP_JALR, 3'd0, 0, 0, 0, 3, mkv(0,0,0,0,0,0,0,0,0,0,1,2,0));
    addv("lui_exec",    OP_LUI, 3'd7, 0, 0, 0, 2, mkv(0,0,0,0,0,0,4,3,1,0,0,0,0));
    addv("auipc_exec",  OP_AUIPC, 3'd7, 0, 0, 0, 2, mkv(0,0,0,0,0,0,4,2,1,0,0,0,0));
    addv("lw_exec",     OP_LD,  3'd2, 0, 0, 0, 2, mkv(0,0,0,0,0,0,1,0,1,0,0,0,0));
    addv("lw_mem",      OP_LD,  3'd2, 0, 0, 0, 3, mkv(1,0,1,0,0,0,0,0,0,0,0,0,0));
    addv("lw_wb",       OP_LD,  3'd2, 0, 0, 0, 4, mkv(0,0,0,0,0,0,0,0,0,0,1,1,0));
    addv("lhu_exec",    OP_LD,  3'd5, 0, 0, 0, 2, mkv(0,0,0,0,0,0,1,0,1,0,0,0,0));
    addv("sw_exec",     OP_ST,  3'd2, 0, 0, 0, 2, mkv(0,0,0,0,0,0,2,0,1,0,0,0,0));
    addv("sw_mem",      OP_ST,  3'd2, 0, 0, 0, 3, mkv(1,1,1,0,0,0,0,0,0,0,0,0,0));
    addv("sw_next",     OP_ST,  3'd2, 0, 0, 0, 4, fetch_r);
    addv("bad_halt",    OP_BAD, 3'd0, 0, 0, 0, 2, halt_v);
    addv("bad_halt_hold", OP_BAD, 3'd0, 0, 0, 0, 6, halt_v);
    addv("bad_nop",     OP_BAD, 3'd0, 0, 0, 1, 2, fetch_r);
    addv("ld_f3_3",     OP_LD,  3'd3, 0, 0, 0, 2, halt_v);
    addv("st_f3_3",     OP_ST,  3'd3, 0, 0, 0, 2, halt_v);
    addv("br_f3_2",     OP_BR,  3'd2, 0, 0, 0, 2, halt_v);
    addv("jalr_f3_1",   OP_JALR, 3'd1, 0, 0, 0, 2, halt_v);

    rst = 1'b1; rdy = 1'b1; op = OP_R; f3 = '0; f75 = 0; zf = 0; ltf = 0; ltuf = 0;
    #12;
    check("reset_outputs_h", 32'(obs_h), 32'd0);
    check("reset_outputs_n", 32'(obs_n), 32'd0);

    foreach (vecs[k]) begin
      do_reset();
      for (int c = 0; c <= vecs[k].cyc; c++)
        step(1'b1, vecs[k].op, vecs[k].f3, vecs[k].f75, vecs[k].z, 1'b0, 1'b0);
      check(vecs[k].name, 32'(vecs[k].use_n ? obs_n : obs_h), 32'(vecs[k].exp));
    end

    // LW with three MEM wait cycles: 8 cycles in total.
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b1, OP_LD, 3'd2, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(k == 3, OP_LD, 3'd2, 0, 0, 0, 0);
      check("lw_wait_req_src_we", 32'({bh.mem_req, bh.mem_src, bh.mem_we}), 32'b110);
    end
    step(1'b0, OP_LD, 3'd2, 0, 0, 0, 0);
    check("lw_wait_wb", 32'({bh.reg_we, bh.wb_sel}), 32'b101);
    step(1'b0, OP_LD, 3'd2, 0, 0, 0, 0);
    check("lw_wait_refetch", 32'({bh.mem_req, bh.mem_src, bh.ir_we}), 32'b100);

    // Reset during a STORE memory wait.
    do_reset();
    step(1'b1, OP_ST, 3'd2, 0, 0, 0, 0);
    step(1'b0, OP_ST, 3'd2, 0, 0, 0, 0);
    step(1'b0, OP_ST, 3'd2, 0, 0, 0, 0);
    step(1'b0, OP_ST, 3'd2, 0, 0, 0, 0);
    check("sw_wait_we", 32'({bh.mem_req, bh.mem_we, bh.mem_src}), 32'b111);
    #1 rst = 1'b1;
    #1 check("sw_rst_async", 32'(obs_h), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; rdy = 1'b0;
    #3 check("post_rst_fetch", 32'({bh.mem_req, bh.mem_src, bh.ir_we, bh.pc_we, bh.mem_we}),
             32'b10000);
    step(1'b0, OP_ST, 3'd2, 0, 0, 0, 0);
    check("post_rst_wait", 32'({bh.mem_req, bh.mem_src, bh.ir_we, bh.pc_we, bh.mem_we}),
          32'b10000);
    step(1'b1, OP_ST, 3'd2, 0, 0, 0, 0);
    check("post_rst_ready", 32'({bh.mem_req, bh.mem_src, bh.ir_we, bh.pc_we, bh.mem_we}),
          32'b10110);

    // HALT holds until reset, then fetch resumes.
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b1, OP_BAD, 3'd0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) step(1'b1, OP_R, 3'd0, 0, 1, 1, 1);
    check("halt_held", 32'(obs_h), 32'(halt_v));
    rdy = 1'b1;
    rst = 1'b1;
    #1 check("halt_rst_clear", 32'(obs_h), 32'd0);
    do_reset();
    step(1'b1, OP_R, 3'd0, 0, 0, 0, 0);
    check("halt_then_fetch", 32'(obs_h), 32'(fetch_r));

    // Random instruction stream against the NOP-on-illegal instance.
    do_reset();
    for (int n = 0; n < 150; n++) begin
      logic [6:0] o, oo;
      logic [2:0] f;
      logic s, z, l, lu, r;
      int fw, mw, cyc, n_ir, n_pc, n_reg, n_req, n_src, n_we, n_halt, last_pcsel, wb_seen;
      bit lg, isld, isst, isbr, isj, isjr, mem, wr, extra;
      o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      f = 3'($urandom); s = 1'($urandom); z = 1'($urandom); l = 1'($urandom);
      lu = 1'($urandom);
      fw = $urandom_range(0, 2); mw = $urandom_range(0, 3);
      lg = ref_legal(o, f);
      isld = (o == OP_LD); isst = (o == OP_ST); isbr = (o == OP_BR);
      isj = (o == OP_JAL); isjr = (o == OP_JALR);
      mem = lg && (isld || isst);
      wr = lg && !isbr && !isst;
      extra = lg && (isj || isjr || (isbr && ref_taken(f, z, l, lu)));
      cyc = fw + 2 + (lg ? 1 + (mem ? mw + 1 : 0) + ((isbr || isst) ? 0 : 1) : 0);
      n_ir = 0; n_pc = 0; n_reg = 0; n_req = 0; n_src = 0; n_we = 0; n_halt = 0;
      last_pcsel = -1; wb_seen = -1;
      for (int i = 0; i < cyc; i++) begin
        if (i < fw) r = 1'b0;
        else if (i == fw) r = 1'b1;
        else if (mem && i >= fw + 3 && i < fw + 3 + mw) r = 1'b0;
        else if (mem && i == fw + 3 + mw) r = 1'b1;
        else r = 1'($urandom_range(0, 1));
        oo = (i <= fw) ? 7'($urandom) : o;
        step(r, oo, f, s, z, l, lu);
        if (i == 0) check($sformatf("rnd%0d_fetch_start", n),
                          32'({bn.mem_req, bn.mem_src}), 32'b10);
        n_ir += int'(bn.ir_we); n_reg += int'(bn.reg_we); n_req += int'(bn.mem_req);
        n_src += int'(bn.mem_src); n_we += int'(bn.mem_we); n_halt += int'(bn.halted);
        if (bn.pc_we) begin n_pc++; last_pcsel = int'(bn.pc_sel); end
        if (bn.reg_we) wb_seen = int'(bn.wb_sel);
      end
      check($sformatf("rnd%0d_ir_we", n), n_ir, 1);
      check($sformatf("rnd%0d_pc_we", n), n_pc, extra ? 2 : 1);
      check($sformatf("rnd%0d_pc_sel", n), last_pcsel, extra ? (isjr ? 2 : 1) : 0);
      check($sformatf("rnd%0d_reg_we", n), n_reg, wr ? 1 : 0);
      check($sformatf("rnd%0d_wb_sel", n), wb_seen, !wr ? -1 : isld ? 1 : (isj || isjr) ? 2 : 0);
      check($sformatf("rnd%0d_mem_req", n), n_req, fw + 1 + (mem ? mw + 1 : 0));
      check($sformatf("rnd%0d_mem_src", n), n_src, mem ? mw + 1 : 0);
      check($sformatf("rnd%0d_mem_we", n), n_we, (mem && isst) ? mw + 1 : 0);
      check($sformatf("rnd%0d_halted", n), n_halt, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
